// File: rtl/led_fc_pkg.sv
// Shared types and constants for the LED driver FC chain setter.
// Holds the FSM state encoding, the reset FC word and the LAT edge-count
// command codes used by the decoder and the top level.
package led_fc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      WAIT_WRT = 2'd2
   } fc_state_e;

   localparam logic [47:0] LED_FC_DEFAULT    = 48'h5c0201008048;
   localparam int unsigned LED_FCWRTEN_EDGES = 15;
   localparam int unsigned LED_WRTFC_EDGES   = 5;
   localparam logic [4:0]  LED_EDGE_CNT_MAX  = 5'd31;

endpackage

// File: rtl/led_lat_cmd_decoder.sv
// LAT command decoder: detects SCLK edges on the system clock and counts
// SCLK rising edges while LAT is high. When LAT drops, the edge count
// identifies the command (FCWRTEN or WRTFC); any other count is ignored.
module led_lat_cmd_decoder
   import led_fc_pkg::*;
#(
   parameter int unsigned FCWRTEN_EDGES = LED_FCWRTEN_EDGES,
   parameter int unsigned WRTFC_EDGES   = LED_WRTFC_EDGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic lat,
   output logic sclk_neg,
   output logic fcwrten,
   output logic wrtfc
);

   logic       sclk_q;
   logic       sclk_pos;
   logic [4:0] cnt_q, cnt_d;

   // Registered SCLK copy and saturating LAT-high edge counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sclk_q <= sclk;
         cnt_q  <= cnt_d;
      end
   end

   // Edge pulses, counter next value and command strobes on the LAT-low clk.
   always_comb begin
      sclk_pos = sclk & ~sclk_q;
      sclk_neg = ~sclk & sclk_q;
      cnt_d    = cnt_q;
      if (!lat) begin
         cnt_d = '0;
      end else if (sclk_pos && (cnt_q != LED_EDGE_CNT_MAX)) begin
         cnt_d = cnt_q + 5'd1;
      end
      fcwrten = ~lat & (cnt_q == 5'(FCWRTEN_EDGES));
      wrtfc   = ~lat & (cnt_q == 5'(WRTFC_EDGES));
   end

endmodule

// File: rtl/led_band_fc_chain_setter.sv
// FC chain setter: shifts a bank of per-driver FC words out on sout,
// farthest driver first, MSB first, paced by the driver SCLK and framed by
// the FCWRTEN / WRTFC LAT commands. HPS writes land in a pending bank that
// is copied to the active bank on FCWRTEN.
// Optional build macro LED_FC_STATUS_EN adds wr_count / err_count outputs.
module led_band_fc_chain_setter
   import led_fc_pkg::*;
#(
   parameter int unsigned          NUM_DRIVERS   = 4,
   parameter int unsigned          FC_WIDTH      = 48,
   parameter logic [FC_WIDTH-1:0]  DEFAULT_FC    = FC_WIDTH'(LED_FC_DEFAULT),
   parameter int unsigned          FCWRTEN_EDGES = LED_FCWRTEN_EDGES,
   parameter int unsigned          WRTFC_EDGES   = LED_WRTFC_EDGES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sclk,
   input  logic                      lat,
   output logic                      sout,
   output logic                      en,
   output logic                      done,
   output logic                      err,
   input  logic                      err_clr,
   input  logic [((NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1)-1:0] hps_fc_addr,
   input  logic [FC_WIDTH-1:0]       hps_fc_data,
   input  logic                      hps_fc_write
`ifdef LED_FC_STATUS_EN
   ,
   output logic [15:0]               wr_count,
   output logic [7:0]                err_count
`endif
);

   localparam int unsigned TOTAL = NUM_DRIVERS * FC_WIDTH;
   localparam int unsigned BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(TOTAL - 1);

   logic [FC_WIDTH-1:0] pend_q [NUM_DRIVERS];
   logic [FC_WIDTH-1:0] act_q  [NUM_DRIVERS];
   logic [TOTAL-1:0]    act_flat;

   fc_state_e           state_q, state_d;
   logic [BW-1:0]       bit_idx_q, bit_idx_d;
   logic                err_q, err_ev;
   logic                done_q, done_d;
   logic                sclk_neg, fcwrten, wrtfc;

   led_lat_cmd_decoder #(
      .FCWRTEN_EDGES (FCWRTEN_EDGES),
      .WRTFC_EDGES   (WRTFC_EDGES)
   ) u_dec (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .lat      (lat),
      .sclk_neg (sclk_neg),
      .fcwrten  (fcwrten),
      .wrtfc    (wrtfc)
   );

   // Pending bank takes HPS writes; active bank snapshots it on FCWRTEN.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_DRIVERS; i++) begin
            pend_q[i] <= DEFAULT_FC;
            act_q[i]  <= DEFAULT_FC;
         end
      end else begin
         if (hps_fc_write && (32'(hps_fc_addr) < NUM_DRIVERS)) begin
            pend_q[hps_fc_addr] <= hps_fc_data;
         end
         if (fcwrten) begin
            for (int unsigned i = 0; i < NUM_DRIVERS; i++) begin
               act_q[i] <= pend_q[i];
            end
         end
      end
   end

   // Flatten the active bank so driver NUM_DRIVERS-1 occupies the top bits.
   always_comb begin
      act_flat = '0;
      for (int unsigned i = 0; i < NUM_DRIVERS; i++) begin
         act_flat[i*FC_WIDTH +: FC_WIDTH] = act_q[i];
      end
   end

   assign sout = act_flat[bit_idx_q];

   // State register with bit index, sticky error (set beats clear) and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_idx_q <= LAST_IDX;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         done_q    <= done_d;
         if (err_ev) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   // Next-state logic; a command arriving out of sequence flags an error.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      err_ev    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fcwrten) begin
               state_d   = SHIFT;
               bit_idx_d = LAST_IDX;
            end else if (wrtfc) begin
               err_ev = 1'b1;
            end
         end
         SHIFT: begin
            if (fcwrten) begin
               err_ev    = 1'b1;
               bit_idx_d = LAST_IDX;
            end else if (wrtfc) begin
               err_ev  = 1'b1;
               state_d = IDLE;
            end else if (sclk_neg) begin
               if (bit_idx_q == '0) begin
                  state_d = WAIT_WRT;
               end else begin
                  bit_idx_d = bit_idx_q - 1'b1;
               end
            end
         end
         WAIT_WRT: begin
            if (fcwrten) begin
               err_ev    = 1'b1;
               state_d   = SHIFT;
               bit_idx_d = LAST_IDX;
            end else if (wrtfc) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: chain released in IDLE, done follows a WRTFC after a full shift.
   always_comb begin
      en     = (state_q == IDLE);
      done_d = (state_q == WAIT_WRT) & wrtfc & ~fcwrten;
   end

   assign done = done_q;
   assign err  = err_q;

`ifdef LED_FC_STATUS_EN
   logic [15:0] wr_count_q;
   logic [7:0]  err_count_q;

   // Completed-write counter (wrapping) and error-event counter (saturating).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count_q  <= '0;
         err_count_q <= '0;
      end else begin
         if (done_d) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
         if (err_ev && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   assign wr_count  = wr_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_led_band_fc_chain_setter.sv
// Scoreboard bench for led_band_fc_chain_setter with two drivers.
// Expected serial bits and done pulses are queued by the stimulus and
// consumed by independent monitors on SCLK rises and done pulses.
// Build with LED_FC_STATUS_EN to also check the status counters.
module tb_led_band_fc_chain_setter;

   localparam int ND = 2;
   localparam int FW = 48;
   localparam logic [FW-1:0] DEF = 48'h5c0201008048;
   localparam logic [FW-1:0] VA  = 48'hA1B2C3D4E5F6;
   localparam logic [FW-1:0] VB  = 48'h0123456789AB;
   localparam logic [FW-1:0] VC  = 48'hFEDCBA987654;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sclk = 1'b0;
   logic          lat = 1'b0;
   logic          sout, en, done, err;
   logic          err_clr = 1'b0;
   logic [0:0]    hps_fc_addr = '0;
   logic [FW-1:0] hps_fc_data = '0;
   logic          hps_fc_write = 1'b0;
`ifdef LED_FC_STATUS_EN
   logic [15:0]   wr_count;
   logic [7:0]    err_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic          exp_bits [$];
   logic          exp_done [$];
   logic [FW-1:0] pend [ND];

   led_band_fc_chain_setter #(
      .NUM_DRIVERS (ND),
      .FC_WIDTH    (FW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sclk         (sclk),
      .lat          (lat),
      .sout         (sout),
      .en           (en),
      .done         (done),
      .err          (err),
      .err_clr      (err_clr),
      .hps_fc_addr  (hps_fc_addr),
      .hps_fc_data  (hps_fc_data),
      .hps_fc_write (hps_fc_write)
`ifdef LED_FC_STATUS_EN
      ,
      .wr_count     (wr_count),
      .err_count    (err_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Serial bit monitor: each SCLK rise during a shift presents one bit.
   always @(posedge sclk) begin
      if (!lat && !en) begin
         if (exp_bits.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sout_extra: got %0b with no expected bit queued", sout);
         end else begin
            check("sout_bit", 64'(sout), 64'(exp_bits.pop_front()));
         end
      end
   end

   // Done monitor: every done pulse must match a queued expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         check("done_expected", 64'(1), 64'(exp_done.size() > 0));
         if (exp_done.size() > 0) void'(exp_done.pop_front());
      end
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic sclk_cycle();
      @(negedge clk) sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic lat_cmd(input int n);
      @(negedge clk) lat = 1'b1;
      repeat (n) sclk_cycle();
      lat = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic shift(input int n);
      repeat (n) sclk_cycle();
   endtask

   task automatic hps_write(input logic [0:0] a, input logic [FW-1:0] d);
      @(negedge clk);
      hps_fc_addr  = a;
      hps_fc_data  = d;
      hps_fc_write = 1'b1;
      @(negedge clk);
      hps_fc_write = 1'b0;
      pend[a] = d;
   endtask

   task automatic push_stream();
      logic [2*FW-1:0] flat;
      flat = {pend[1], pend[0]};
      for (int i = 2*FW-1; i >= 0; i--) exp_bits.push_back(flat[i]);
   endtask

   task automatic clear_err();
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      check("err_cleared", 64'(err), 64'(0));
   endtask

   task automatic full_write();
      push_stream();
      exp_done.push_back(1'b1);
      lat_cmd(15);
      check("en_shift", 64'(en), 64'(0));
      shift(96);
      check("bits_left", 64'(exp_bits.size()), 64'(0));
      lat_cmd(5);
      repeat (3) @(negedge clk);
      check("done_left", 64'(exp_done.size()), 64'(0));
      check("en_idle", 64'(en), 64'(1));
      check("err_ok", 64'(err), 64'(0));
   endtask

   initial begin
      logic s0;
      pend[0] = DEF;
      pend[1] = DEF;
      repeat (3) @(negedge clk);
      check("rst_en", 64'(en), 64'(1));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_sout", 64'(sout), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // WRTFC while idle is a protocol error
      lat_cmd(5);
      check("idle_wrtfc_err", 64'(err), 64'(1));
      check("idle_wrtfc_en", 64'(en), 64'(1));
      clear_err();

      // Full write, farthest driver (addr 1) first
      hps_write(1'b1, VA);
      hps_write(1'b0, VB);
      full_write();

      // HPS write during shift does not disturb the current stream
      push_stream();
      exp_done.push_back(1'b1);
      lat_cmd(15);
      shift(20);
      hps_write(1'b1, VC);
      shift(76);
      lat_cmd(5);
      repeat (3) @(negedge clk);
      check("mid_write_done", 64'(exp_done.size()), 64'(0));
      check("mid_write_bits", 64'(exp_bits.size()), 64'(0));
      full_write();

      // Unrecognised edge counts are ignored
      s0 = sout;
      lat_cmd(14);
      check("e14_en", 64'(en), 64'(1));
      check("e14_sout", 64'(sout), 64'(s0));
      check("e14_err", 64'(err), 64'(0));
      lat_cmd(16);
      check("e16_en", 64'(en), 64'(1));
      check("e16_sout", 64'(sout), 64'(s0));
      check("e16_err", 64'(err), 64'(0));

      // Early WRTFC after 40 bits aborts with error, no done
      push_stream();
      lat_cmd(15);
      shift(40);
      check("early_bits_left", 64'(exp_bits.size()), 64'(56));
      exp_bits.delete();
      lat_cmd(5);
      repeat (3) @(negedge clk);
      check("early_err", 64'(err), 64'(1));
      check("early_en", 64'(en), 64'(1));
      clear_err();

      // FCWRTEN mid-shift restarts the stream and flags an error
      push_stream();
      lat_cmd(15);
      shift(10);
      check("restart_bits_left", 64'(exp_bits.size()), 64'(86));
      exp_bits.delete();
      push_stream();
      exp_done.push_back(1'b1);
      lat_cmd(15);
      check("restart_err", 64'(err), 64'(1));
      check("restart_en", 64'(en), 64'(0));
      shift(96);
      lat_cmd(5);
      repeat (3) @(negedge clk);
      check("restart_done", 64'(exp_done.size()), 64'(0));
      check("restart_bits", 64'(exp_bits.size()), 64'(0));
      clear_err();

      // Reset at bit 30 aborts silently and restores defaults
      push_stream();
      lat_cmd(15);
      shift(30);
      check("rst_bits_left", 64'(exp_bits.size()), 64'(66));
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_bits.delete();
      @(negedge clk);
      check("midrst_en", 64'(en), 64'(1));
      check("midrst_err", 64'(err), 64'(0));
      check("midrst_sout", 64'(sout), 64'(0));
      pend[0] = DEF;
      pend[1] = DEF;
      full_write();

      // Two more good writes and one early WRTFC since the reset
      hps_write(1'b0, VA);
      full_write();
      full_write();
      push_stream();
      lat_cmd(15);
      shift(40);
      exp_bits.delete();
      lat_cmd(5);
      repeat (3) @(negedge clk);
      check("early2_err", 64'(err), 64'(1));
`ifdef LED_FC_STATUS_EN
      check("wr_count", 64'(wr_count), 64'(3));
      check("err_count", 64'(err_count), 64'(1));
`endif
      clear_err();

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_band_fc_chain_setter.md
LED_BAND_FC_CHAIN_SETTER -- requirements
Module: led_band_fc_chain_setter

Interface
REQ-001 SHALL have parameter NUM_DRIVERS, default 4: number of daisy-chained LED drivers; legal range 1..16.
REQ-002 SHALL have parameter FC_WIDTH, default 48: FC bits per driver.
REQ-003 SHALL have parameter DEFAULT_FC, default 48'h5c0201008048: reset FC value loaded for every driver.
REQ-004 SHALL have parameter FCWRTEN_EDGES, default 15: SCLK rising edges with LAT high that identify FCWRTEN.
REQ-005 SHALL have parameter WRTFC_EDGES, default 5: SCLK rising edges with LAT high that identify WRTFC.
REQ-006 SHALL have the following ports (clock and reset first); reset is rst, synchronous, active-high, and the clock is clk:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sclk  in  1  driver serial clock, sampled on clk.
- lat  in  1  driver latch, sampled on clk.
- sout  out  1  serial FC data, MSB first.
- en  out  1  high when the block is not driving the chain.
- done  out  1  one-clk pulse on a completed FC write.
- err  out  1  sticky protocol-error flag.
- err_clr  in  1  clears err.
- hps_fc_addr  in  $clog2(NUM_DRIVERS) (minimum 1)  driver index.
- hps_fc_data  in  FC_WIDTH  FC word.
- hps_fc_write  in  1  write strobe.

Function
REQ-007 SHALL register sclk once per clk and derive single-clk posedge/negedge pulses from the current and registered values.
REQ-008 SHALL count SCLK posedges while lat=1 in a 5-bit counter that saturates at 31 and clears on any clk with lat=0.
REQ-009 SHALL assert fcwrten for exactly the first clk with lat=0 after a high period whose count equals FCWRTEN_EDGES; wrtfc SHALL behave the same way for WRTFC_EDGES; all other counts SHALL be ignored.
REQ-010 SHALL hold a pending bank of NUM_DRIVERS FC words; hps_fc_write writes hps_fc_data to pending[hps_fc_addr] on the same clk; writes with addr >= NUM_DRIVERS SHALL be ignored.
REQ-011 SHALL copy the whole pending bank to an active bank on the fcwrten clk; HPS writes during a shift SHALL affect only the pending bank.
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and WAIT_WRT; en=1 in IDLE, en=0 otherwise.
REQ-013 IDLE + fcwrten: load bit_idx = NUM_DRIVERS*FC_WIDTH-1 and go to SHIFT.
REQ-014 sout SHALL equal bit bit_idx of the concatenation {active[NUM_DRIVERS-1], ..., active[0]}, so the farthest driver is sent first, MSB first.
REQ-015 SHIFT + negedge pulse: if bit_idx=0 go to WAIT_WRT and hold bit_idx; otherwise decrement bit_idx.
REQ-016 WAIT_WRT + wrtfc: go to IDLE and pulse done for 1 clk.
REQ-017 SHIFT + wrtfc (early): set err and go to IDLE; done SHALL NOT pulse.
REQ-018 SHIFT or WAIT_WRT + fcwrten: set err, reload the active bank and bit_idx, and stay in or enter SHIFT.
REQ-019 IDLE + wrtfc: set err and stay in IDLE.
REQ-020 err_clr SHALL clear err unless an error event occurs in the same clk, in which case set wins.
REQ-021 The upstream sync module SHALL drop LAT only while SCLK is low; the block does not handle other LAT timing.

Reset
REQ-022 On rst: state=IDLE, en=1, done=0, err=0, edge counter=0, registered sclk=0, bit_idx=NUM_DRIVERS*FC_WIDTH-1, and both banks = DEFAULT_FC for every driver.
REQ-023 rst asserted mid-shift SHALL abort the write with no done or err pulse, and SHALL override every other input in that clk.

Configuration
REQ-024 With LED_FC_STATUS_EN defined, the block SHALL add outputs wr_count[15:0] and err_count[7:0], both reset to 0.
- wr_count SHALL increment on each done pulse and wrap from 0xFFFF to 0.
- err_count SHALL increment on each err-setting event and saturate at 0xFF.
REQ-025 Without LED_FC_STATUS_EN, those ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-026 Package led_fc_pkg SHALL hold the FSM state enum, the DEFAULT_FC constant and the edge-count constants 15 and 5.
REQ-027 Sub-module led_lat_cmd_decoder SHALL contain the SCLK edge detection and LAT edge counter, and emit fcwrten, wrtfc and the negedge pulse.

Verification
REQ-028 With NUM_DRIVERS=2 and pending {A,B} written: FCWRTEN, then 96 SCLK cycles, then WRTFC -> sout carries A[47..0] then B[47..0], en low for the whole shift, and done pulses once.
REQ-029 Write addr=1 during a shift -> the current bitstream is unchanged and the next write sends the new value.
REQ-030 WRTFC after 40 SCLK cycles -> err=1, state IDLE, no done; then err_clr -> err=0.
REQ-031 LAT high for 14 or 16 edges -> no state change and sout stable.
REQ-032 rst asserted at bit 30 -> en=1, and the next FCWRTEN sends DEFAULT_FC for both drivers.
REQ-033 With LED_FC_STATUS_EN defined: 3 good writes and 1 early WRTFC -> wr_count=3 and err_count=1.
